// File: rtl/counter_ctrl.sv
// Index sequencer for the autoencoder: sweeps 0..limit once per pass for PASSES passes,
// stepping only on consumer acceptance, then emits a one-cycle completion pulse.
module counter_ctrl #(
    parameter int CNT_W  = 5,
    parameter int PASS_W = 2,
    parameter int PASSES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  limit,
    input  logic              advance,
    output logic [CNT_W-1:0]  count_out,
    output logic              count_valid,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              wrap,
    output logic              done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

    logic [1:0]        state_r;
    logic [1:0]        state_s;
    logic [CNT_W-1:0]  limit_r;
    logic [CNT_W-1:0]  limit_s;
    logic [CNT_W-1:0]  count_s;
    logic [PASS_W-1:0] pass_s;
    logic              wrap_s;
    logic              done_s;

    // Next-state and next-output computation for the sweep sequencer.
    always_comb begin
        state_s = state_r;
        limit_s = limit_r;
        count_s = count_out;
        pass_s  = pass_idx;
        wrap_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                    limit_s = limit;
                    count_s = {CNT_W{1'b0}};
                    pass_s  = {PASS_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    // End of pass is detected by compare, so limit=all-ones never relies on overflow.
                    if (count_out < limit_r) begin
                        count_s = count_out + CNT_W'(1);
                    end else begin
                        count_s = {CNT_W{1'b0}};
                        wrap_s  = 1'b1;
                        if (pass_idx < LAST_PASS) begin
                            pass_s = pass_idx + PASS_W'(1);
                        end else begin
                            state_s = ST_DONE;
                            done_s  = 1'b1;
                        end
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                count_s = {CNT_W{1'b0}};
                pass_s  = {PASS_W{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
                count_s = {CNT_W{1'b0}};
                pass_s  = {PASS_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs, with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            limit_r     <= {CNT_W{1'b0}};
            count_out   <= {CNT_W{1'b0}};
            pass_idx    <= {PASS_W{1'b0}};
            count_valid <= 1'b0;
            busy        <= 1'b0;
            wrap        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_s;
            limit_r     <= limit_s;
            count_out   <= count_s;
            pass_idx    <= pass_s;
            count_valid <= (state_s == ST_RUN);
            busy        <= (state_s != ST_IDLE);
            wrap        <= wrap_s;
            done        <= done_s;
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: an accept-count model checked every cycle,
// plus directed literal checks that pin the model.
`timescale 1ns/1ps
module tb_counter_ctrl;

    localparam int CNT_W  = 5;
    localparam int PASS_W = 2;
    localparam int PASSES = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  limit;
    logic              advance;
    logic [CNT_W-1:0]  count_out;
    logic              count_valid;
    logic [PASS_W-1:0] pass_idx;
    logic              busy;
    logic              wrap;
    logic              done;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    counter_ctrl #(.CNT_W(CNT_W), .PASS_W(PASS_W), .PASSES(PASSES)) dut (
        .clk(clk), .rst(rst), .start(start), .limit(limit), .advance(advance),
        .count_out(count_out), .count_valid(count_valid), .pass_idx(pass_idx),
        .busy(busy), .wrap(wrap), .done(done)
    );

    always #5 clk = ~clk;

    // Model: a run is described by the number of accepted indices k;
    // index = k mod (limit+1), pass = k div (limit+1), run ends at k = PASSES*(limit+1).
    int m_phase = 0;   // 0 idle, 1 sweeping, 2 completion cycle
    int m_k     = 0;
    int m_lim   = 0;
    bit e_wrap  = 1'b0;
    bit e_done  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_k     <= 0;
            m_lim   <= 0;
            e_wrap  <= 1'b0;
            e_done  <= 1'b0;
        end else begin
            e_wrap <= 1'b0;
            e_done <= 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    m_phase <= 1;
                    m_k     <= 0;
                    m_lim   <= int'(limit);
                end
            end else if (m_phase == 1) begin
                if (advance) begin
                    m_k <= m_k + 1;
                    if ((m_k + 1) % (m_lim + 1) == 0) e_wrap <= 1'b1;
                    if (m_k + 1 == PASSES * (m_lim + 1)) begin
                        e_done  <= 1'b1;
                        m_phase <= 2;
                    end
                end
            end else begin
                m_phase <= 0;
            end
        end
    end

    function automatic int exp_count();
        return (m_phase == 1) ? (m_k % (m_lim + 1)) : 0;
    endfunction

    function automatic int exp_pass();
        if (m_phase == 1) return m_k / (m_lim + 1);
        else if (m_phase == 2) return PASSES - 1;
        else return 0;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            cmp("m_count_out",   int'(count_out),   exp_count());
            cmp("m_count_valid", int'(count_valid), (m_phase == 1) ? 1 : 0);
            cmp("m_pass_idx",    int'(pass_idx),    exp_pass());
            cmp("m_busy",        int'(busy),        (m_phase != 0) ? 1 : 0);
            cmp("m_wrap",        int'(wrap),        int'(e_wrap));
            cmp("m_done",        int'(done),        int'(e_done));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic run_to_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 80) begin
            cyc();
            n++;
        end
        cmp({name, "_done_reached"}, int'(done === 1'b1), 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; advance = 1'b0; limit = 5'd0;
        cyc();
        check_en = 1'b1;
        // Reset held with advance toggling
        advance = 1'b1; cyc();
        advance = 1'b0; cyc();
        cmp("rst_count", int'(count_out), 0);
        cmp("rst_valid", int'(count_valid), 0);
        cmp("rst_busy",  int'(busy), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            advance = ~advance;
            cyc();
        end
        cmp("idle_busy", int'(busy), 0);
        cmp("idle_wrap", int'(wrap), 0);

        // Basic run, limit 3
        limit = 5'd3; start = 1'b1; advance = 1'b1;
        cyc();
        start = 1'b0;
        cmp("basic_first_idx", int'(count_out), 0);
        cmp("basic_valid", int'(count_valid), 1);
        for (int i = 1; i < 8; i++) begin
            cyc();
            cmp("basic_idx", int'(count_out), i % 4);
            cmp("basic_wrap", int'(wrap), (i == 4) ? 1 : 0);
            cmp("basic_pass", int'(pass_idx), (i >= 4) ? 1 : 0);
        end
        cyc();
        cmp("basic_done", int'(done), 1);
        cmp("basic_done_wrap", int'(wrap), 1);
        cmp("basic_done_valid", int'(count_valid), 0);
        cmp("basic_done_pass", int'(pass_idx), 1);
        advance = 1'b0;
        cyc();
        cmp("basic_idle_busy", int'(busy), 0);
        cmp("basic_idle_done", int'(done), 0);

        // Stall with a mid-run start
        limit = 5'd4; start = 1'b1; advance = 1'b1;
        cyc();
        start = 1'b0;
        cmp("stall_idx0", int'(count_out), 0);
        cyc();
        cmp("stall_idx1", int'(count_out), 1);
        advance = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        cmp("stall_hold_a", int'(count_out), 1);
        cyc();
        cmp("stall_hold_b", int'(count_out), 1);
        advance = 1'b1;
        cyc();
        cmp("stall_idx2", int'(count_out), 2);
        run_to_done("stall");
        advance = 1'b0;
        cyc();

        // limit 0: every accept wraps
        limit = 5'd0; start = 1'b1;
        cyc();
        start = 1'b0; advance = 1'b1;
        cyc();
        cmp("lim0_wrap1", int'(wrap), 1);
        cmp("lim0_pass1", int'(pass_idx), 1);
        cmp("lim0_nodone", int'(done), 0);
        cyc();
        cmp("lim0_wrap2", int'(wrap), 1);
        cmp("lim0_done", int'(done), 1);
        advance = 1'b0;
        cyc();

        // limit 31, then abort in pass 1 at index 2
        limit = 5'd31; start = 1'b1;
        cyc();
        start = 1'b0; advance = 1'b1;
        for (int i = 0; i < 31; i++) cyc();
        cmp("lim31_top", int'(count_out), 31);
        cyc();
        cmp("lim31_wrap_idx", int'(count_out), 0);
        cmp("lim31_wrap", int'(wrap), 1);
        cmp("lim31_pass", int'(pass_idx), 1);
        cyc(); cyc();
        cmp("abort_pre_idx", int'(count_out), 2);
        rst = 1'b1;
        cyc();
        rst = 1'b0; advance = 1'b0;
        cmp("abort_idx", int'(count_out), 0);
        cmp("abort_busy", int'(busy), 0);
        cmp("abort_done", int'(done), 0);
        cmp("abort_valid", int'(count_valid), 0);
        cyc();
        cmp("abort_after_done", int'(done), 0);
        limit = 5'd1; start = 1'b1;
        cyc();
        start = 1'b0; advance = 1'b1;
        run_to_done("restart");
        advance = 1'b0;
        cyc();

        // Limit captured at start; start during DONE ignored; back-to-back start
        limit = 5'd2; start = 1'b1;
        cyc();
        start = 1'b0; limit = 5'd7; advance = 1'b1;
        cyc(); cyc();
        cmp("cap_idx2", int'(count_out), 2);
        cyc();
        cmp("cap_wrap", int'(wrap), 1);
        cmp("cap_idx0", int'(count_out), 0);
        cyc(); cyc(); cyc();
        cmp("cap_done", int'(done), 1);
        start = 1'b1;
        cyc();
        cmp("b2b_idle_busy", int'(busy), 0);
        cmp("b2b_idle_pass", int'(pass_idx), 0);
        cyc();
        start = 1'b0; advance = 1'b0;
        cmp("b2b_valid", int'(count_valid), 1);
        cmp("b2b_idx", int'(count_out), 0);
        advance = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        cmp("b2b_lim7_idx", int'(count_out), 4);
        rst = 1'b1;
        cyc();
        rst = 1'b0; advance = 1'b0;
        cyc(); cyc();
        check_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
